// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine.
// Turns the ID-stage memory-control bundle plus the ALU address into a single
// request/ready transaction on a variable-latency data RAM. It stalls the
// pipeline while the access is outstanding, returns aligned and extended load
// data, and reports misaligned accesses and RAM timeouts instead of performing them.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] mem_addr,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ready,
    output logic [31:0] read_data,
    output logic        stall_request,
    output logic        addr_error,
    output logic        bus_error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Encoded access size kept across the BUSY phase for load extraction
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] wait_count;
    logic        load_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [31:0] result_q;
    logic        timeout_q;

    logic        size_ok;
    logic        access;
    logic        misaligned;
    logic        start;
    logic [1:0]  size_code;
    logic [3:0]  lanes;
    logic [31:0] store_word;
    logic [31:0] shifted;
    logic [31:0] load_value;

    // Decode the incoming bundle: size, validity, alignment, lanes and replicated store data
    always_comb begin
        size_ok    = (mem_sel == 4'b0001) || (mem_sel == 4'b0011) || (mem_sel == 4'b1111);
        access     = (mem_read_flag || mem_write_flag) && size_ok;
        misaligned = ((mem_sel == 4'b0011) && mem_addr[0]) ||
                     ((mem_sel == 4'b1111) && (mem_addr[1:0] != 2'b00));
        start      = (state == IDLE) && access && !misaligned;
        lanes      = mem_write_flag ? (mem_sel << mem_addr[1:0]) : 4'b0000;
        size_code  = SIZE_WORD;
        store_word = mem_write_data;
        case (mem_sel)
            4'b0001: begin
                size_code  = SIZE_BYTE;
                store_word = {4{mem_write_data[7:0]}};
            end
            4'b0011: begin
                size_code  = SIZE_HALF;
                store_word = {2{mem_write_data[15:0]}};
            end
            default: begin
                size_code  = SIZE_WORD;
                store_word = mem_write_data;
            end
        endcase
    end

    // Pull the addressed byte/half out of the returned word and extend it
    always_comb begin
        shifted    = ram_read_data >> {offset_q, 3'b000};
        load_value = shifted;
        case (size_q)
            SIZE_BYTE: load_value = sign_q ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'd0, shifted[7:0]};
            SIZE_HALF: load_value = sign_q ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'd0, shifted[15:0]};
            default:   load_value = ram_read_data;
        endcase
    end

    // Pipeline-facing outputs derive from the state so they react within the issue cycle
    always_comb begin
        ram_en        = (state == BUSY);
        stall_request = start || (state == BUSY);
        addr_error    = (state == IDLE) && access && misaligned;
        read_data     = (state == DONE) ? result_q : 32'd0;
        bus_error     = (state == DONE) && timeout_q;
    end

    // Access FSM: latch the request in IDLE, wait for ready or timeout in BUSY, present the result in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wait_count     <= 16'd0;
            ram_write_en   <= 4'b0000;
            ram_addr       <= 32'd0;
            ram_write_data <= 32'd0;
            load_q         <= 1'b0;
            sign_q         <= 1'b0;
            size_q         <= SIZE_WORD;
            offset_q       <= 2'b00;
            result_q       <= 32'd0;
            timeout_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= BUSY;
                        wait_count     <= 16'd0;
                        ram_write_en   <= lanes;
                        ram_addr       <= {mem_addr[31:2], 2'b00};
                        ram_write_data <= mem_write_flag ? store_word : 32'd0;
                        load_q         <= !mem_write_flag;
                        sign_q         <= mem_sign_ext_flag;
                        size_q         <= size_code;
                        offset_q       <= mem_addr[1:0];
                        result_q       <= 32'd0;
                        timeout_q      <= 1'b0;
                    end
                end
                BUSY: begin
                    if (ram_ready) begin
                        state    <= DONE;
                        result_q <= load_q ? load_value : 32'd0;
                    end else if (wait_count == LAST_WAIT) begin
                        state     <= DONE;
                        result_q  <= 32'd0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    timeout_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores push expected
// RAM requests and results; a monitor pops them when the DUT presents them.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] mem_addr;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ready;
    logic [31:0] read_data;
    logic        stall_request;
    logic        addr_error;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        berr;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_flag     (mem_read_flag),
        .mem_write_flag    (mem_write_flag),
        .mem_sign_ext_flag (mem_sign_ext_flag),
        .mem_sel           (mem_sel),
        .mem_write_data    (mem_write_data),
        .mem_addr          (mem_addr),
        .ram_en            (ram_en),
        .ram_write_en      (ram_write_en),
        .ram_addr          (ram_addr),
        .ram_write_data    (ram_write_data),
        .ram_read_data     (ram_read_data),
        .ram_ready         (ram_ready),
        .read_data         (read_data),
        .stall_request     (stall_request),
        .addr_error        (addr_error),
        .bus_error         (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        mem_read_flag     = 1'b0;
        mem_write_flag    = 1'b0;
        mem_sign_ext_flag = 1'b0;
        mem_sel           = 4'b0000;
        mem_write_data    = 32'd0;
        mem_addr          = 32'd0;
    endtask

    // Issue one access at the current negedge, act as the RAM (ready in the
    // n-th BUSY cycle, n=0 means never) and check cycle counts
    task automatic applyStimulus(input string name, input logic rd, input logic wr, input logic sx,
                                 input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] addr,
                                 input logic [31:0] word, input int n,
                                 input logic [31:0] exp_addr, input logic [3:0] exp_we,
                                 input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                                 input logic exp_berr);
        int en_cyc;
        int st_cyc;
        int cyc;
        int busy_cycles;
        bit done;
        req_t  rq;
        resp_t rs;
        rq.addr = exp_addr; rq.we = exp_we; rq.wdata = exp_wdata;
        rs.rdata = exp_rdata; rs.berr = exp_berr;
        req_q.push_back(rq);
        resp_q.push_back(rs);
        busy_cycles       = (n == 0) ? 4 : n;
        mem_read_flag     = rd;
        mem_write_flag    = wr;
        mem_sign_ext_flag = sx;
        mem_sel           = sel;
        mem_write_data    = wd;
        mem_addr          = addr;
        ram_read_data     = word;
        ram_ready         = 1'b0;
        en_cyc = 0; st_cyc = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 50) begin
            #1;
            if (stall_request) st_cyc++;
            if (ram_en) begin
                en_cyc++;
                ram_ready = (n != 0) && (en_cyc == n);
            end else begin
                ram_ready = 1'b0;
            end
            cyc++;
            if (!stall_request && !ram_en) begin
                done = 1'b1;
                clearInputs();
            end
            @(negedge clk);
        end
        ram_ready = 1'b0;
        checkOutput({name, " cycles"}, 32'(cyc), 32'(busy_cycles + 2));
        checkOutput({name, " ram_en cycles"}, 32'(en_cyc), 32'(busy_cycles));
        checkOutput({name, " stall cycles"}, 32'(st_cyc), 32'(busy_cycles + 1));
    endtask

    // Drive an access that must never reach the RAM and check the error flag
    task automatic applyNoAccess(input string name, input logic rd, input logic wr,
                                 input logic [3:0] sel, input logic [31:0] addr, input logic exp_err);
        mem_read_flag  = rd;
        mem_write_flag = wr;
        mem_sel        = sel;
        mem_addr       = addr;
        #1;
        checkOutput({name, " addr_error"}, 32'(addr_error), 32'(exp_err));
        checkOutput({name, " stall"}, 32'(stall_request), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput({name, " ram_en"}, 32'(ram_en), 32'd0);
            checkOutput({name, " read_data"}, read_data, 32'd0);
        end
        clearInputs();
        @(negedge clk);
    endtask

    // Monitor: compare the RAM request as BUSY begins and the result in the DONE cycle
    initial begin
        logic prev_en;
        req_t  rq;
        resp_t rs;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && ram_en && !prev_en) begin
                if (req_q.size() == 0) begin
                    checkOutput("unexpected request", 32'd1, 32'd0);
                end else begin
                    rq = req_q.pop_front();
                    checkOutput("ram_addr", ram_addr, rq.addr);
                    checkOutput("ram_write_en", 32'(ram_write_en), 32'(rq.we));
                    if (rq.we != 4'b0000) checkOutput("ram_write_data", ram_write_data, rq.wdata);
                end
            end
            if (rst && prev_en && !ram_en) begin
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected result", 32'd1, 32'd0);
                end else begin
                    rs = resp_q.pop_front();
                    checkOutput("read_data", read_data, rs.rdata);
                    checkOutput("bus_error", 32'(bus_error), 32'(rs.berr));
                end
            end else if (bus_error) begin
                checkOutput("stray bus_error", 32'(bus_error), 32'd0);
            end
            prev_en = rst ? ram_en : 1'b0;
        end
    end

    initial begin
        clearInputs();
        ram_read_data = 32'd0;
        ram_ready     = 1'b0;
        rst           = 1'b0;
        #1;
        checkOutput("reset ram_en", 32'(ram_en), 32'd0);
        checkOutput("reset read_data", read_data, 32'd0);
        checkOutput("reset stall", 32'(stall_request), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        applyStimulus("lw 0x100", 1, 0, 0, 4'b1111, 32'd0, 32'h100, 32'hDEADBEEF, 1,
                      32'h100, 4'b0000, 32'd0, 32'hDEADBEEF, 0);
        applyStimulus("lb 0x103", 1, 0, 1, 4'b0001, 32'd0, 32'h103, 32'h80FF1234, 2,
                      32'h100, 4'b0000, 32'd0, 32'hFFFFFF80, 0);
        applyStimulus("lbu 0x103", 1, 0, 0, 4'b0001, 32'd0, 32'h103, 32'h80FF1234, 1,
                      32'h100, 4'b0000, 32'd0, 32'h00000080, 0);
        applyStimulus("lh 0x102", 1, 0, 1, 4'b0011, 32'd0, 32'h102, 32'h80FF1234, 1,
                      32'h100, 4'b0000, 32'd0, 32'hFFFF80FF, 0);
        applyStimulus("lbu 0x101", 1, 0, 0, 4'b0001, 32'd0, 32'h101, 32'h80FF1234, 1,
                      32'h100, 4'b0000, 32'd0, 32'h00000012, 0);
        applyStimulus("sb 0x201", 0, 1, 0, 4'b0001, 32'h000000AB, 32'h201, 32'd0, 1,
                      32'h200, 4'b0010, 32'hABABABAB, 32'd0, 0);
        applyStimulus("sh 0x202", 0, 1, 0, 4'b0011, 32'h00001234, 32'h202, 32'd0, 2,
                      32'h200, 4'b1100, 32'h12341234, 32'd0, 0);
        applyStimulus("sw 0x204", 0, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h204, 32'h55555555, 1,
                      32'h204, 4'b1111, 32'hCAFEF00D, 32'd0, 0);
        applyStimulus("rd+wr 0x208", 1, 1, 0, 4'b1111, 32'h01020304, 32'h208, 32'hFFFFFFFF, 1,
                      32'h208, 4'b1111, 32'h01020304, 32'd0, 0);

        applyNoAccess("lw 0x102 misaligned", 1, 0, 4'b1111, 32'h102, 1);
        applyNoAccess("sh 0x101 misaligned", 0, 1, 4'b0011, 32'h101, 1);
        applyNoAccess("bad sel", 1, 0, 4'b0010, 32'h100, 0);

        applyStimulus("timeout lw 0x400", 1, 0, 0, 4'b1111, 32'd0, 32'h400, 32'h12345678, 0,
                      32'h400, 4'b0000, 32'd0, 32'd0, 1);

        // Reset while BUSY: access abandoned, outputs back to reset values at once
        mem_read_flag = 1'b1;
        mem_sel       = 4'b1111;
        mem_addr      = 32'h300;
        @(posedge clk);
        #2;
        checkOutput("pre-reset ram_en", 32'(ram_en), 32'd1);
        rst = 1'b0;
        clearInputs();
        #1;
        checkOutput("mid-reset ram_en", 32'(ram_en), 32'd0);
        checkOutput("mid-reset ram_addr", ram_addr, 32'd0);
        checkOutput("mid-reset stall", 32'(stall_request), 32'd0);
        checkOutput("mid-reset bus_error", 32'(bus_error), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Back-to-back loads, ready in the third BUSY cycle
        applyStimulus("b2b lw 0x10", 1, 0, 0, 4'b1111, 32'd0, 32'h10, 32'h11223344, 3,
                      32'h10, 4'b0000, 32'd0, 32'h11223344, 0);
        applyStimulus("b2b lhu 0x12", 1, 0, 0, 4'b0011, 32'd0, 32'h12, 32'h8765ABCD, 3,
                      32'h10, 4'b0000, 32'd0, 32'h00008765, 0);

        repeat (3) @(negedge clk);
        checkOutput("req queue drained", 32'(req_q.size()), 32'd0);
        checkOutput("resp queue drained", 32'(resp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
